// File: rtl/aes_key_schedule_ctrl.sv
// aes_key_schedule_ctrl: sequential AES-128 key expansion, one round key per clock, with a registered round-key read port
module aes_key_schedule_ctrl #(
  parameter int Nk = 4,
  parameter int Nr = 10
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [32*Nk-1:0] keyIn,
  output logic             busy,
  output logic             done,
  output logic             keyReady,
  input  logic [3:0]       rkAddr,
  output logic [32*Nk-1:0] rkOut
);
  localparam int KW = 32 * Nk;
  localparam logic [3:0] NR = 4'(Nr);

  typedef enum logic [1:0] {S_IDLE, S_EXPAND, S_DONE} state_t;

  state_t          r_state, w_next;
  logic [3:0]      r_cnt;
  logic            r_done;
  logic            w_load;
  logic [KW-1:0]   r_rk [0:Nr];
  logic [KW-1:0]   r_last;
  logic [KW-1:0]   r_rk_out;
  logic [31:0]     w_rot, w_sub, w_t, w_w0, w_w1, w_w2, w_w3;
  logic [KW-1:0]   w_new;

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = '0;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = xtime(x);
    end
    return p;
  endfunction

  // S-box as GF(2^8) inverse (x^254, which maps 0 to 0) followed by the affine transform
  function automatic logic [7:0] sbox(input logic [7:0] x);
    logic [7:0] p;
    logic [7:0] r;
    p = x;
    r = 8'h01;
    for (int i = 1; i < 8; i++) begin
      p = gf_mul(p, p);
      r = gf_mul(r, p);
    end
    return r ^ {r[6:0], r[7]} ^ {r[5:0], r[7:6]} ^ {r[4:0], r[7:5]} ^ {r[3:0], r[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [7:0] rcon(input logic [3:0] n);
    logic [7:0] r;
    r = 8'h01;
    for (int j = 1; j < 10; j++)
      if (4'(j) < n) r = xtime(r);
    return r;
  endfunction

  // next-state decode and status flags derived from the current state
  always_comb begin
    w_load   = start && (r_state != S_EXPAND);
    busy     = (r_state == S_EXPAND);
    keyReady = (r_state == S_DONE);
    w_next   = (r_state == S_EXPAND) ? ((r_cnt == NR) ? S_DONE : S_EXPAND)
                                     : (start ? S_EXPAND : r_state);
  end

  // single KeyExpansionRound applied to the most recently written round key
  always_comb begin
    w_rot = {r_last[23:0], r_last[31:24]};
    w_sub = {sbox(w_rot[31:24]), sbox(w_rot[23:16]), sbox(w_rot[15:8]), sbox(w_rot[7:0])};
    w_t   = w_sub ^ {rcon(r_cnt), 24'h0};
    w_w0  = r_last[127:96] ^ w_t;
    w_w1  = r_last[95:64] ^ w_w0;
    w_w2  = r_last[63:32] ^ w_w1;
    w_w3  = r_last[31:0] ^ w_w2;
    w_new = {w_w0, w_w1, w_w2, w_w3};
  end

  // state, round counter, done pulse and the registered read port
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= S_IDLE;
      r_cnt    <= '0;
      r_done   <= 1'b0;
      r_rk_out <= '0;
    end else begin
      r_state  <= w_next;
      r_cnt    <= w_load ? 4'd1 : ((busy && r_cnt != NR) ? r_cnt + 4'd1 : r_cnt);
      r_done   <= busy && (r_cnt == NR);
      r_rk_out <= (rkAddr > NR) ? '0 : r_rk[rkAddr];
    end
  end

  // round-key buffer; r_last mirrors rk[counter-1] so the round function needs no array read
  always_ff @(posedge clk) begin
    if (!reset && w_load) begin
      r_rk[0] <= keyIn;
      r_last  <= keyIn;
    end else if (!reset && busy) begin
      r_rk[r_cnt] <= w_new;
      r_last      <= w_new;
    end
  end

  assign done  = r_done;
  assign rkOut = r_rk_out;
endmodule

// File: tb/tb_aes_key_schedule_ctrl.sv
// tb_aes_key_schedule_ctrl: scoreboard bench for the AES-128 key schedule controller
module tb_aes_key_schedule_ctrl;
  localparam logic [127:0] K    = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] K_R1 = 128'ha0fafe1788542cb123a339392a6c7605;
  localparam logic [127:0] K_RA = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
  localparam logic [127:0] J    = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] J_R1 = 128'hd6aa74fdd2af72fadaa678f1d6ab76fe;
  localparam logic [127:0] J_RA = 128'h13111d7fe3944a17f307a78b4d2b30c5;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         start = 1'b0;
  logic [127:0] keyIn = '0;
  logic [3:0]   rkAddr = '0;
  logic         busy, done, keyReady;
  logic [127:0] rkOut;

  typedef struct {
    string        name;
    logic [127:0] act;
    logic [127:0] exp;
  } chk_t;

  chk_t flag_q[$];
  chk_t rd_q[$];
  int   n_pass = 0;
  int   n_total = 0;
  logic rd_issue = 1'b0;
  logic rd_pend = 1'b0;

  aes_key_schedule_ctrl #(.Nk(4), .Nr(10)) dut (
    .clk(clk), .reset(reset), .start(start), .keyIn(keyIn),
    .busy(busy), .done(done), .keyReady(keyReady),
    .rkAddr(rkAddr), .rkOut(rkOut)
  );

  always #5 clk = ~clk;

  function automatic void cmp(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endfunction

  // a read request issued before an edge has its data valid after that edge
  always @(posedge clk) rd_pend <= rd_issue;

  // monitor: drains flag expectations and pops a read expectation whenever read data is presented
  always @(negedge clk) begin
    chk_t e;
    while (flag_q.size() > 0) begin
      e = flag_q.pop_front();
      cmp(e.name, e.act, e.exp);
    end
    if (rd_pend) begin
      if (rd_q.size() == 0) begin
        n_total++;
        $display("FAIL rd_scoreboard: got read data %h with no expectation queued", rkOut);
      end else begin
        e = rd_q.pop_front();
        cmp(e.name, rkOut, e.exp);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    chk_t e;
    e.name = name;
    e.act  = act;
    e.exp  = exp;
    flag_q.push_back(e);
  endtask

  task automatic rd(input string name, input logic [3:0] a, input logic [127:0] exp);
    chk_t e;
    e.name = name;
    e.act  = '0;
    e.exp  = exp;
    rd_q.push_back(e);
    rkAddr   = a;
    rd_issue = 1'b1;
    tick();
    rd_issue = 1'b0;
  endtask

  task automatic kick(input logic [127:0] k);
    keyIn = k;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_done(output int n, output int nb);
    n  = 1;
    nb = 0;
    while (!done && n < 40) begin
      nb += int'(busy);
      tick();
      n++;
    end
  endtask

  task automatic count_done(input int cycles, output int nd);
    nd = 0;
    repeat (cycles) begin
      nd += int'(done);
      tick();
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int n, nb, nd;
    reset = 1'b1;
    tick();
    rd("reset_rkOut", 4'd5, '0);
    chk("reset_busy", 128'(busy), 0);
    chk("reset_done", 128'(done), 0);
    chk("reset_keyReady", 128'(keyReady), 0);
    reset = 1'b0;
    rd("oor_idle", 4'd11, '0);

    kick(K);
    wait_done(n, nb);
    chk("latency", 128'(n), 11);
    chk("busy_cycles", 128'(nb), 10);
    chk("keyReady_at_done", 128'(keyReady), 1);
    chk("busy_at_done", 128'(busy), 0);
    tick();
    chk("done_one_pulse", 128'(done), 0);
    repeat (3) tick();
    chk("keyReady_hold", 128'(keyReady), 1);
    rd("rk0", 4'd0, K);
    rd("rk1", 4'd1, K_R1);
    rd("rk10", 4'd10, K_RA);
    for (int a = 11; a < 16; a++) rd("oor_done", 4'(a), '0);

    kick(K);
    repeat (3) tick();
    kick('0);
    count_done(20, nd);
    chk("start_busy_single_done", 128'(nd), 1);
    chk("start_busy_keyReady", 128'(keyReady), 1);
    rd("start_busy_rk10", 4'd10, K_RA);
    rd("start_busy_rk0", 4'd0, K);

    kick(J);
    chk("rekey_keyReady_drop", 128'(keyReady), 0);
    chk("rekey_busy", 128'(busy), 1);
    rd("oor_expand", 4'd13, '0);
    wait_done(n, nb);
    chk("rekey_done_seen", 128'(done), 1);
    rd("rekey_rk1", 4'd1, J_R1);

    kick(K);
    repeat (4) tick();
    reset = 1'b1;
    rd("midreset_rkOut", 4'd0, '0);
    reset = 1'b0;
    chk("midreset_busy", 128'(busy), 0);
    chk("midreset_keyReady", 128'(keyReady), 0);
    count_done(15, nd);
    chk("midreset_no_done", 128'(nd), 0);
    chk("midreset_keyReady_stays_low", 128'(keyReady), 0);
    kick(J);
    wait_done(n, nb);
    chk("latency_after_reset", 128'(n), 11);
    rd("after_reset_rk10", 4'd10, J_RA);

    tick();
    tick();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
